// File: rtl/gen_pad_reader.sv
// Host-side reader for a Mega Drive 3/6-button pad on a DB9/SNAC port.
// Drives TH through an 8-phase scan, samples the pad lines at the end of
// each phase, detects pad presence and the 6-button ID, and publishes one
// button word per scan together with a single-cycle VALID strobe.
module gen_pad_reader #(
  parameter int PHASE_LEN = 16,
  parameter int IDLE_LEN  = 16000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        EN,
  input  logic [5:0]  PAD_IN,
  output logic        TH,
  output logic [11:0] BUTTONS,
  output logic        PRESENT,
  output logic        SIX,
  output logic        VALID
);

  localparam int TICK_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int IDLE_W = (IDLE_LEN > 1) ? $clog2(IDLE_LEN) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [2:0]          phase_reg, phase_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic [11:0]         shadow_reg, shadow_next;
  logic                pres_reg, pres_next;
  logic                six_reg, six_next;
  logic                th_reg, th_next;
  logic [11:0]         buttons_reg, buttons_next;
  logic                present_reg, present_next;
  logic                six_out_reg, six_out_next;

  logic [5:0]          pad_meta_reg, pad_sync_reg;
  logic [5:0]          s;

  // Pad lines are asynchronous to CLK; two flops before any use.
  // Released (unpressed) lines idle high, so that is the reset value.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pad_meta_reg <= 6'h3F;
      pad_sync_reg <= 6'h3F;
    end else begin
      pad_meta_reg <= PAD_IN;
      pad_sync_reg <= pad_meta_reg;
    end
  end

  // Active-high view of the synchronised lines (low on the wire = pressed).
  assign s = ~pad_sync_reg;

  // Scan sequencing, per-phase sampling and result publication.
  // Results are loaded on the way into COMMIT so they are already stable
  // during the cycle in which VALID is high.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    phase_next   = phase_reg;
    idle_next    = idle_reg;
    shadow_next  = shadow_reg;
    pres_next    = pres_reg;
    six_next     = six_reg;
    th_next      = th_reg;
    buttons_next = buttons_reg;
    present_next = present_reg;
    six_out_next = six_out_reg;
    VALID        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        th_next = 1'b1;
        if (CE) begin
          if (!EN) begin
            idle_next = '0;
          end else if (idle_reg == IDLE_LAST) begin
            state_next  = ST_SCAN;
            tick_next   = '0;
            phase_next  = 3'd0;
            idle_next   = '0;
            shadow_next = 12'h000;
            pres_next   = 1'b0;
            six_next    = 1'b0;
          end else begin
            idle_next = idle_reg + IDLE_W'(1);
          end
        end
      end

      ST_SCAN: begin
        if (CE) begin
          if (!EN) begin
            // Abort: nothing is published, previous outputs stay.
            state_next = ST_IDLE;
            idle_next  = '0;
            th_next    = 1'b1;
          end else if (tick_reg == TICK_LAST) begin
            case (phase_reg)
              3'd0: begin
                shadow_next[6] = s[5];
                shadow_next[5] = s[4];
                shadow_next[3] = s[3];
                shadow_next[2] = s[2];
                shadow_next[1] = s[1];
                shadow_next[0] = s[0];
              end
              3'd1: begin
                shadow_next[7] = s[5];
                shadow_next[4] = s[4];
                pres_next      = (pad_sync_reg[3:2] == 2'b00);
              end
              3'd5: begin
                six_next = pres_reg & (pad_sync_reg[3:0] == 4'b0000);
              end
              3'd6: begin
                if (six_reg) begin
                  shadow_next[6]  = s[5];
                  shadow_next[5]  = s[4];
                  shadow_next[8]  = s[3];
                  shadow_next[9]  = s[2];
                  shadow_next[10] = s[1];
                  shadow_next[11] = s[0];
                end
              end
              default: begin
              end
            endcase

            tick_next = '0;
            if (phase_reg == 3'd7) begin
              state_next   = ST_COMMIT;
              th_next      = 1'b1;
              present_next = pres_reg;
              six_out_next = six_reg;
              if (!pres_reg) begin
                buttons_next = 12'h000;
              end else if (six_reg) begin
                buttons_next = shadow_reg;
              end else begin
                buttons_next = {4'b0000, shadow_reg[7:0]};
              end
            end else begin
              phase_next = phase_reg + 3'd1;
              // Next phase is even (TH high) exactly when this one is odd.
              th_next    = phase_reg[0];
            end
          end else begin
            tick_next = tick_reg + TICK_W'(1);
          end
        end
      end

      ST_COMMIT: begin
        th_next = 1'b1;
        if (CE) begin
          VALID      = 1'b1;
          state_next = ST_IDLE;
          idle_next  = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        idle_next  = '0;
        th_next    = 1'b1;
      end
    endcase
  end

  // State, counters, shadow and published outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      tick_reg    <= '0;
      phase_reg   <= 3'd0;
      idle_reg    <= '0;
      shadow_reg  <= 12'h000;
      pres_reg    <= 1'b0;
      six_reg     <= 1'b0;
      th_reg      <= 1'b1;
      buttons_reg <= 12'h000;
      present_reg <= 1'b0;
      six_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      phase_reg   <= phase_next;
      idle_reg    <= idle_next;
      shadow_reg  <= shadow_next;
      pres_reg    <= pres_next;
      six_reg     <= six_next;
      th_reg      <= th_next;
      buttons_reg <= buttons_next;
      present_reg <= present_next;
      six_out_reg <= six_out_next;
    end
  end

  assign TH      = th_reg;
  assign BUTTONS = buttons_reg;
  assign PRESENT = present_reg;
  assign SIX     = six_out_reg;

endmodule

// File: tb/tb_gen_pad_reader.sv
// Bench for gen_pad_reader: a behavioural Mega Drive pad (none / 3-button /
// 6-button, TH edge counter with inactivity timeout) answers the reader;
// results are compared against a button-set reference model.
module tb_gen_pad_reader;

  localparam int PL          = 4;
  localparam int IL          = 40;
  localparam int PAD_TIMEOUT = 30;
  localparam int PERIOD      = IL + 8 * PL + 1;
  localparam int WAIT_LIMIT  = 2000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        ce    = 1'b1;
  logic        en    = 1'b1;
  logic [5:0]  pad_in;
  logic        th;
  logic [11:0] buttons;
  logic        present;
  logic        six;
  logic        valid;

  gen_pad_reader #(.PHASE_LEN(PL), .IDLE_LEN(IL)) dut (
    .CLK(clk), .RESET(reset), .CE(ce), .EN(en), .PAD_IN(pad_in),
    .TH(th), .BUTTONS(buttons), .PRESENT(present), .SIX(six), .VALID(valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural pad ----------------
  // kind: 0 = nothing plugged, 1 = 3-button, 2 = 6-button.
  // pressed uses the {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP} order.
  int          pad_kind = 0;
  logic [11:0] pressed  = 12'h000;
  int          jcnt     = 0;
  int          quiet    = 0;
  logic        th_prev  = 1'b1;

  // Count TH rising edges; forget them after PAD_TIMEOUT quiet clocks.
  always @(posedge clk) begin
    th_prev <= th;
    if (th && !th_prev) begin
      jcnt  <= (jcnt < 7) ? jcnt + 1 : jcnt;
      quiet <= 0;
    end else if (quiet >= PAD_TIMEOUT) begin
      jcnt <= 0;
    end else begin
      quiet <= quiet + 1;
    end
  end

  always_comb begin
    pad_in = 6'h3F;
    if (pad_kind != 0) begin
      if (th) begin
        if (pad_kind == 2 && jcnt == 3)
          pad_in = ~{pressed[6], pressed[5], pressed[8], pressed[9], pressed[10], pressed[11]};
        else
          pad_in = ~{pressed[6], pressed[5], pressed[3], pressed[2], pressed[1], pressed[0]};
      end else begin
        if (pad_kind == 2 && jcnt == 2)
          pad_in = {~pressed[7], ~pressed[4], 4'b0000};
        else if (pad_kind == 2 && jcnt == 3)
          pad_in = {~pressed[7], ~pressed[4], 4'b1111};
        else
          pad_in = {~pressed[7], ~pressed[4], 2'b00, ~pressed[1], ~pressed[0]};
      end
    end
  end

  // What the reader should report for a given pad and held buttons.
  function automatic void ref_model(input int kind, input logic [11:0] p,
                                    output logic [11:0] b, output logic pr, output logic sx);
    if (kind == 0) begin
      b = 12'h000; pr = 1'b0; sx = 1'b0;
    end else if (kind == 1) begin
      b = p & 12'h0FF; pr = 1'b1; sx = 1'b0;
    end else begin
      b = p; pr = 1'b1; sx = 1'b1;
    end
  endfunction

  // ---------------- CE driver ----------------
  bit ce_rand  = 1'b0;
  int ce_zeros = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (ce_rand && ce_zeros < 2 && $urandom_range(0, 3) == 0) begin
        ce = 1'b0;
        ce_zeros++;
      end else begin
        ce = 1'b1;
        ce_zeros = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int          valid_count   = 0;
  int          ce_ticks      = 0;
  int          ce_viol       = 0;
  int          th_falls      = 0;
  int          low_len       = 0;
  int          scan_pulses   = 0;
  int          scan_width_bad = 0;
  logic        th_last       = 1'b1;
  logic [11:0] cap_buttons   = 12'h000;
  logic        cap_present   = 1'b0;
  logic        cap_six       = 1'b0;
  int          cap_tick      = 0;
  int          cap_pulses    = 0;
  int          cap_width_bad = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (valid && !ce) ce_viol++;
      if (reset) begin
        th_last = 1'b1; low_len = 0; scan_pulses = 0; scan_width_bad = 0;
      end else begin
        if (th_last && !th) th_falls++;
        if (!th && ce) low_len++;
        if (!th_last && th) begin
          scan_pulses++;
          if (low_len != PL) scan_width_bad++;
          low_len = 0;
        end
        th_last = th;
        if (valid) begin
          valid_count++;
          cap_buttons   = buttons;
          cap_present   = present;
          cap_six       = six;
          cap_tick      = ce_ticks;
          cap_pulses    = scan_pulses;
          cap_width_bad = scan_width_bad;
          scan_pulses    = 0;
          scan_width_bad = 0;
        end
      end
      if (ce) ce_ticks++;
    end
  end

  task automatic wait_valid(output bit ok);
    int start;
    start = valid_count;
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      #2;
      if (valid_count != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      #2;
      if (th_falls >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          kind;
    logic [11:0] pressed;
    logic [11:0] exp_buttons;
    logic        exp_present;
    logic        exp_six;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          ok;
    int          rel_tick;
    int          prev_tick;
    int          base;
    int          vc;
    int          kind;
    logic [11:0] p;
    logic [11:0] eb;
    logic        ep;
    logic        es;

    vecs[0] = '{1, 12'h011, 12'h011, 1'b1, 1'b0};   // 3-button, A+UP
    vecs[1] = '{2, 12'h288, 12'h288, 1'b1, 1'b1};   // 6-button, X+START+RIGHT
    vecs[2] = '{0, 12'h5A5, 12'h000, 1'b0, 1'b0};   // nothing plugged
    vecs[3] = '{1, 12'h3A4, 12'h0A4, 1'b1, 1'b0};   // 3-button drops MODE/X
    vecs[4] = '{2, 12'h940, 12'h940, 1'b1, 1'b1};   // 6-button MODE+Z+C
    vecs[5] = '{2, 12'h000, 12'h000, 1'b1, 1'b1};   // 6-button, idle pad
    vecs[6] = '{2, 12'hFFD, 12'hFFD, 1'b1, 1'b1};   // back-to-back 6-button scan

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_th", th, 1'b1);
    check("reset_buttons", buttons, 12'h000);
    check("reset_present", present, 1'b0);
    check("reset_six", six, 1'b0);
    check("reset_valid", valid, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    rel_tick = ce_ticks;
    wait_valid(ok);
    check("first_valid_seen", ok, 1'b1);
    check("first_valid_latency", cap_tick - rel_tick, IL + 8 * PL);
    check("first_buttons_nopad", cap_buttons, 12'h000);

    // Table vectors, CE always high.
    for (int i = 0; i < 7; i++) begin
      pad_kind  = vecs[i].kind;
      pressed   = vecs[i].pressed;
      prev_tick = cap_tick;
      wait_valid(ok);
      check($sformatf("vec%0d_valid", i), ok, 1'b1);
      check($sformatf("vec%0d_buttons", i), cap_buttons, vecs[i].exp_buttons);
      check($sformatf("vec%0d_present", i), cap_present, vecs[i].exp_present);
      check($sformatf("vec%0d_six", i), cap_six, vecs[i].exp_six);
      check($sformatf("vec%0d_th_pulses", i), cap_pulses, 4);
      check($sformatf("vec%0d_th_width", i), cap_width_bad, 0);
      check($sformatf("vec%0d_period", i), cap_tick - prev_tick, PERIOD);
      $display("vec %0d kind=%0d pressed=%03h buttons=%03h present=%0d six=%0d",
               i, vecs[i].kind, vecs[i].pressed, cap_buttons, cap_present, cap_six);
    end

    // Random pads and buttons with CE gating.
    ce_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 2);
      p = 12'($urandom);
      if (p[0] && p[1]) p[1] = 1'b0;       // a d-pad cannot press UP and DOWN together
      pad_kind = kind;
      pressed  = p;
      ref_model(kind, p, eb, ep, es);
      wait_valid(ok);
      check($sformatf("rnd%0d_valid", i), ok, 1'b1);
      check($sformatf("rnd%0d_buttons", i), cap_buttons, eb);
      check($sformatf("rnd%0d_present", i), cap_present, ep);
      check($sformatf("rnd%0d_six", i), cap_six, es);
      $display("rnd %0d kind=%0d pressed=%03h buttons=%03h present=%0d six=%0d",
               i, kind, p, cap_buttons, cap_present, cap_six);
    end

    // EN dropped in phase 3: immediate abort, no publication.
    ce_rand  = 1'b0;
    pad_kind = 2;
    pressed  = 12'h0F0;
    wait_valid(ok);
    check("abort_prescan_buttons", cap_buttons, 12'h0F0);
    pad_kind = 1;
    pressed  = 12'h00C;
    base = th_falls;
    wait_falls(base + 2, ok);
    check("abort_reach_phase3", ok, 1'b1);
    @(negedge clk);
    check("abort_th_low_before", th, 1'b0);
    en = 1'b0;
    @(negedge clk);
    #1;
    check("abort_th_high", th, 1'b1);
    vc = valid_count;
    repeat (3 * PERIOD) @(negedge clk);
    #1;
    check("abort_no_valid", valid_count, vc);
    check("abort_buttons_held", buttons, 12'h0F0);
    check("abort_present_held", present, 1'b1);
    check("abort_six_held", six, 1'b1);
    check("abort_th_idle", th, 1'b1);
    $display("abort: th=%0d buttons=%03h valid_count=%0d", th, buttons, valid_count);
    en = 1'b1;
    wait_valid(ok);
    check("abort_resume_valid", ok, 1'b1);
    check("abort_resume_buttons", cap_buttons, 12'h00C);
    check("abort_resume_six", cap_six, 1'b0);

    // RESET pulsed in phase 5.
    pad_kind = 2;
    pressed  = 12'hA51;
    base = th_falls;
    wait_falls(base + 3, ok);
    check("rst_reach_phase5", ok, 1'b1);
    @(negedge clk);
    check("rst_th_low_before", th, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_th", th, 1'b1);
    check("rst_buttons", buttons, 12'h000);
    check("rst_present", present, 1'b0);
    check("rst_valid", valid, 1'b0);
    $display("reset: th=%0d buttons=%03h present=%0d valid=%0d", th, buttons, present, valid);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel_tick = ce_ticks;
    ce_rand = 1'b1;
    wait_valid(ok);
    check("rst_next_valid", ok, 1'b1);
    check("rst_next_latency", cap_tick - rel_tick, IL + 8 * PL);
    check("rst_next_buttons", cap_buttons, 12'hA51);
    check("rst_next_six", cap_six, 1'b1);
    $display("after reset: latency=%0d buttons=%03h", cap_tick - rel_tick, cap_buttons);

    check("valid_only_on_ce", ce_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
